id_ex_stage: RTL and testbench

// - RV32I decode stage plus ID/EX pipeline register. Sits between the IF/ID register and the execute stage.
// - Drives the register-file read addresses and captures the read data.
// - Generates the immediate and a minimal control set.
// - Detects load-use hazards and registers everything into the E stage with bubble/flush support.

---
 rtl/id_ex_stage.sv | 178 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register with load-use stall and flush bubble.
// Optional WB_BYPASS_EN forwards the same-cycle write-back result into the captured operands.
module id_ex_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            validD,
  output logic [4:0]      A1,
  output logic [4:0]      A2,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            StallF,
  output logic            StallD,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [31:0]     InstrE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            IsLoadE,
  output logic            IllegalE,
  output logic            validE
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_write;
    logic            is_load;
    logic            illegal;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } ex_t;

  // Reset and bubble share one encoding: an invisible addi x0,x0,0.
  localparam ex_t BUBBLE = '{valid: 1'b0, reg_write: 1'b0, mem_write: 1'b0,
                             is_load: 1'b0, illegal: 1'b0, rs1: 5'd0, rs2: 5'd0,
                             rd: 5'd0, instr: NOP_INSTR, imm: '0, rd1: '0,
                             rd2: '0, pc: '0, pc_plus4: '0};

  ex_t             e_d, e_q;
  logic [XLEN-1:0] imm_d;
  logic            writes_rd, mem_write_d, is_load_d, illegal_d;
  logic [XLEN-1:0] rd1_d, rd2_d;
  logic            hz;

  assign A1 = InstrD[19:15];
  assign A2 = InstrD[24:20];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    imm_d       = '0;
    writes_rd   = 1'b0;
    mem_write_d = 1'b0;
    is_load_d   = 1'b0;
    illegal_d   = 1'b0;
    case (InstrD[6:0])
      OP_LOAD: begin
        imm_d     = {{20{InstrD[31]}}, InstrD[31:20]};
        writes_rd = 1'b1;
        is_load_d = 1'b1;
      end
      OP_ALUI, OP_JALR: begin
        imm_d     = {{20{InstrD[31]}}, InstrD[31:20]};
        writes_rd = 1'b1;
      end
      OP_STORE: begin
        imm_d       = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
        mem_write_d = 1'b1;
      end
      OP_BRANCH: imm_d = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                          InstrD[11:8], 1'b0};
      OP_LUI, OP_AUIPC: begin
        imm_d     = {InstrD[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        imm_d     = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                     InstrD[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OP_ALU:  writes_rd = 1'b1;
      default: illegal_d = 1'b1;
    endcase
  end

  // The register file writes on the edge but reads combinationally, so a
  // same-cycle write-back is otherwise missed by the operand capture.
  always_comb begin
`ifdef WB_BYPASS_EN
    rd1_d = (RegWriteW && (RdW != 5'd0) && (RdW == A1)) ? ResultW : RD1;
    rd2_d = (RegWriteW && (RdW != 5'd0) && (RdW == A2)) ? ResultW : RD2;
`else
    rd1_d = RD1;
    rd2_d = RD2;
`endif
  end

  // Conservative: compares rs fields even for formats that do not read them.
  assign hz = e_q.valid & e_q.is_load & (e_q.rd != 5'd0) &
              ((e_q.rd == A1) | (e_q.rd == A2)) & validD;

  assign StallF = hz;
  assign StallD = hz;

  always_comb begin
    e_d = BUBBLE;
    if (!FlushE && !hz && validD) begin
      e_d.valid     = 1'b1;
      e_d.reg_write = writes_rd & (InstrD[11:7] != 5'd0);
      e_d.mem_write = mem_write_d;
      e_d.is_load   = is_load_d;
      e_d.illegal   = illegal_d;
      e_d.rs1       = A1;
      e_d.rs2       = A2;
      e_d.rd        = InstrD[11:7];
      e_d.instr     = InstrD;
      e_d.imm       = imm_d;
      e_d.rd1       = rd1_d;
      e_d.rd2       = rd2_d;
      e_d.pc        = PCD;
      e_d.pc_plus4  = PCPlus4D;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) e_q <= BUBBLE;
    else      e_q <= e_d;
  end

  assign validE    = e_q.valid;
  assign RegWriteE = e_q.reg_write;
  assign MemWriteE = e_q.mem_write;
  assign IsLoadE   = e_q.is_load;
  assign IllegalE  = e_q.illegal;
  assign Rs1E      = e_q.rs1;
  assign Rs2E      = e_q.rs2;
  assign RdE       = e_q.rd;
  assign InstrE    = e_q.instr;
  assign ImmExtE   = e_q.imm;
  assign RD1E      = e_q.rd1;
  assign RD2E      = e_q.rd2;
  assign PCE       = e_q.pc;
  assign PCPlus4E  = e_q.pc_plus4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected E contents are queued when D is driven
// and popped one edge later for comparison.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        validD;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        FlushE;
  logic        StallF, StallD;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, InstrE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, IsLoadE, IllegalE, validE;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        valid, rw, mw, ld, ill;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] instr, imm, rd1, rd2, pc, pc4;
    bit          chk_imm;
  } exp_t;

  exp_t sb[$];

  id_ex_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .validD(validD), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .StallF(StallF), .StallD(StallD), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .InstrE(InstrE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .IsLoadE(IsLoadE), .IllegalE(IllegalE), .validE(validE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e = '{valid: 1'b0, rw: 1'b0, mw: 1'b0, ld: 1'b0, ill: 1'b0, rd: 5'd0,
          rs1: 5'd0, rs2: 5'd0, instr: 32'h0000_0013, imm: 32'h0, rd1: 32'h0,
          rd2: 32'h0, pc: 32'h0, pc4: 32'h0, chk_imm: 1'b1};
    return e;
  endfunction

  // Register indices are plain field extraction; everything decoded is supplied by the caller.
  function automatic exp_t mk(input logic [31:0] instr, input logic rw, input logic mw,
                              input logic ld, input logic ill, input logic [31:0] imm,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] pc);
    exp_t e;
    e = '{valid: 1'b1, rw: rw, mw: mw, ld: ld, ill: ill, rd: instr[11:7],
          rs1: instr[19:15], rs2: instr[24:20], instr: instr, imm: imm, rd1: rd1,
          rd2: rd2, pc: pc, pc4: pc + 32'd4, chk_imm: 1'b1};
    return e;
  endfunction

  task automatic set_d(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic v);
    InstrD   = instr;
    PCD      = pc;
    PCPlus4D = pc + 32'd4;
    RD1      = rd1;
    RD2      = rd2;
    validD   = v;
  endtask

  // Push the expectation, take one edge, then pop and compare away from the edge.
  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tests_run++;
    assert (sb.size() != 0) else begin
      tests_failed++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end
    if (sb.size() != 0) begin
      got = sb.pop_front();
      check({tag, "_validE"},    {31'd0, validE},    {31'd0, got.valid});
      check({tag, "_RegWriteE"}, {31'd0, RegWriteE}, {31'd0, got.rw});
      check({tag, "_MemWriteE"}, {31'd0, MemWriteE}, {31'd0, got.mw});
      check({tag, "_IsLoadE"},   {31'd0, IsLoadE},   {31'd0, got.ld});
      check({tag, "_IllegalE"},  {31'd0, IllegalE},  {31'd0, got.ill});
      check({tag, "_RdE"},       {27'd0, RdE},       {27'd0, got.rd});
      check({tag, "_Rs1E"},      {27'd0, Rs1E},      {27'd0, got.rs1});
      check({tag, "_Rs2E"},      {27'd0, Rs2E},      {27'd0, got.rs2});
      check({tag, "_InstrE"},    InstrE,             got.instr);
      if (got.chk_imm) check({tag, "_ImmExtE"}, ImmExtE, got.imm);
      check({tag, "_RD1E"},      RD1E,               got.rd1);
      check({tag, "_RD2E"},      RD2E,               got.rd2);
      check({tag, "_PCE"},       PCE,                got.pc);
      check({tag, "_PCPlus4E"},  PCPlus4E,           got.pc4);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    #1;
    check({tag, "_StallF"}, {31'd0, StallF}, {31'd0, exp});
    check({tag, "_StallD"}, {31'd0, StallD}, {31'd0, exp});
  endtask

  initial begin
    exp_t e;
    logic [31:0] byp;
    rst = 1'b0; FlushE = 1'b0;
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0;
    set_d(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Reset for two cycles with random D inputs
    for (int i = 0; i < 2; i++) begin
      set_d($urandom, $urandom, $urandom, $urandom, 1'b1);
      step("reset", bubble());
      chk_stall("reset", 1'b0);
    end
    rst = 1'b1;

    // addi x5,x1,-1
    set_d(32'hFFF08293, 32'h100, 32'd7, 32'd0, 1'b1);
    #1;
    check("addi_A1", {27'd0, A1}, 32'd1);
    check("addi_A2", {27'd0, A2}, 32'd31);
    step("addi", mk(32'hFFF08293, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'h100));

    // lw x6,0(x2) then dependent add x7,x6,x1
    set_d(32'h00012303, 32'h104, 32'h40, 32'h55, 1'b1);
    chk_stall("lw", 1'b0);
    step("lw", mk(32'h00012303, 1, 0, 1, 0, 32'h0, 32'h40, 32'h55, 32'h104));
    set_d(32'h001303B3, 32'h108, 32'h11, 32'h22, 1'b1);
    chk_stall("use", 1'b1);
    step("use_bubble", bubble());
    chk_stall("use_retry", 1'b0);
    step("add", mk(32'h001303B3, 1, 0, 0, 0, 32'h0, 32'h11, 32'h22, 32'h108));

    // Same-cycle write-back to the rs1 register
    set_d(32'h01018413, 32'h10C, 32'h0, 32'h33, 1'b1);
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hDEADBEEF;
`ifdef WB_BYPASS_EN
    byp = 32'hDEADBEEF;
`else
    byp = 32'h0;
`endif
    step("wb_rd3", mk(32'h01018413, 1, 0, 0, 0, 32'h10, byp, 32'h33, 32'h10C));
    RdW = 5'd0;
    step("wb_rd0", mk(32'h01018413, 1, 0, 0, 0, 32'h10, 32'h0, 32'h33, 32'h10C));
    RegWriteW = 1'b0;

    // addi x0,x0,5 must not write
    set_d(32'h00500013, 32'h110, 32'h0, 32'h0, 1'b1);
    step("x0", mk(32'h00500013, 0, 0, 0, 0, 32'h5, 32'h0, 32'h0, 32'h110));

    // Opcode 7'b1111111: immediate is unspecified
    set_d(32'h00000FFF, 32'h114, 32'h1, 32'h2, 1'b1);
    e = mk(32'h00000FFF, 0, 0, 0, 1, 32'h0, 32'h1, 32'h2, 32'h114);
    e.chk_imm = 1'b0;
    step("illegal", e);

    // Remaining immediate formats
    set_d(32'h00512423, 32'h118, 32'h3, 32'h4, 1'b1);
    step("sw", mk(32'h00512423, 0, 1, 0, 0, 32'h8, 32'h3, 32'h4, 32'h118));
    set_d(32'hFE000EE3, 32'h11C, 32'h5, 32'h6, 1'b1);
    step("beq", mk(32'hFE000EE3, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h5, 32'h6, 32'h11C));
    set_d(32'h12345537, 32'h120, 32'h7, 32'h8, 1'b1);
    step("lui", mk(32'h12345537, 1, 0, 0, 0, 32'h1234_5000, 32'h7, 32'h8, 32'h120));
    set_d(32'h001000EF, 32'h124, 32'h9, 32'hA, 1'b1);
    step("jal", mk(32'h001000EF, 1, 0, 0, 0, 32'h800, 32'h9, 32'hA, 32'h124));

    // validD=0 is captured as a bubble
    set_d(32'hFFF08293, 32'h128, 32'h7, 32'h0, 1'b0);
    step("invalid", bubble());

    // A load to x0 never causes a stall
    set_d(32'h00012003, 32'h12C, 32'h1, 32'h2, 1'b1);
    step("lw_x0", mk(32'h00012003, 0, 0, 1, 0, 32'h0, 32'h1, 32'h2, 32'h12C));
    set_d(32'h000003B3, 32'h130, 32'h3, 32'h4, 1'b1);
    chk_stall("use_x0", 1'b0);
    step("add_x0", mk(32'h000003B3, 1, 0, 0, 0, 32'h0, 32'h3, 32'h4, 32'h130));

    // Flush together with a load-use hazard
    set_d(32'h00012303, 32'h134, 32'h40, 32'h55, 1'b1);
    step("lw2", mk(32'h00012303, 1, 0, 1, 0, 32'h0, 32'h40, 32'h55, 32'h134));
    set_d(32'h001303B3, 32'h138, 32'h11, 32'h22, 1'b1);
    FlushE = 1'b1;
    chk_stall("flush_hz", 1'b1);
    step("flush_hz", bubble());
    chk_stall("flush_only", 1'b0);
    step("flush_only", bubble());
    FlushE = 1'b0;

    // Mid-operation reset discards E
    set_d(32'h00012303, 32'h13C, 32'h40, 32'h55, 1'b1);
    step("lw3", mk(32'h00012303, 1, 0, 1, 0, 32'h0, 32'h40, 32'h55, 32'h13C));
    set_d(32'h001303B3, 32'h140, 32'h11, 32'h22, 1'b1);
    rst = 1'b0;
    step("mid_reset", bubble());
    chk_stall("mid_reset", 1'b0);
    rst = 1'b1;
    step("post_reset", mk(32'h001303B3, 1, 0, 0, 0, 32'h0, 32'h11, 32'h22, 32'h140));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
